// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK command sequencer: op codes, FSM state
// encoding and the op -> {j,k} drive decode.
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Returns {j, k} for a command op.
  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO, DEPTH x W.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jk_cmd_fifo
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // A push while full is refused even when a pop lands in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command-driven j/k stimulus for a JK flip-flop with a cycle-accurate q model.
// Define JK_SEQ_CHECK_EN to build the q_fb checker (mismatch / err_cnt).
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             q_exp,
  input  logic             q_fb,
  output logic             mismatch,
  output logic [7:0]       err_cnt,
  output seq_state_e       dbg_state
);

  localparam int FW = 2 + CNT_W;

  // Handshake: a command transfers at a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on FIFO fullness.
  seq_state_e       state_q;
  logic             j_q, k_q, done_q, q_exp_q;
  logic [CNT_W-1:0] rem_q;
  logic [FW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_len;
  logic [1:0]       head_jk;
  logic             fifo_full, fifo_empty, pop;

  assign head_op  = head[FW-1 -: 2];
  assign head_len = head[CNT_W-1:0];
  assign head_jk  = op_to_jk(head_op);
  assign pop      = !fifo_empty && ((state_q == ST_IDLE) || (rem_q == '0));

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid),
    .wdata ({cmd_op, cmd_len}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {j_q, k_q} <= head_jk;
            rem_q      <= head_len;
            done_q     <= (head_len == '0);
            state_q    <= ST_RUN;
          end else begin
            j_q    <= 1'b0;
            k_q    <= 1'b0;
            done_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (rem_q != '0) begin
            rem_q  <= rem_q - CNT_W'(1);
            done_q <= (rem_q == CNT_W'(1));
          end else if (!fifo_empty) begin
            // Chain straight into the next command: no idle bubble.
            {j_q, k_q} <= head_jk;
            rem_q      <= head_len;
            done_q     <= (head_len == '0);
          end else begin
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) q_exp_q <= 1'b0;
    else       q_exp_q <= (j_q & ~q_exp_q) | (~k_q & q_exp_q);
  end

  assign cmd_ready = !fifo_full;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign q_exp     = q_exp_q;
  assign dbg_state = state_q;

`ifdef JK_SEQ_CHECK_EN
  logic       armed_q, mismatch_q;
  logic [7:0] err_cnt_q;

  // The flip-flop powers up unknown; only a completed RESET/SET cycle makes q known.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if ((state_q == ST_RUN) && (j_q ^ k_q)) armed_q <= 1'b1;
      if (armed_q && (q_fb != q_exp_q)) begin
        mismatch_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer; inputs change and outputs are checked
// on the falling edge, one step per clock cycle.
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  logic       j, k, busy, done, q_exp, q_fb, mismatch;
  logic [7:0] err_cnt;
  seq_state_e dbg_state;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [2:0] exp_q[$];
  logic [1:0] jk_q[$];

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_exp     (q_exp),
    .q_fb      (q_fb),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Driver and check tasks
  task automatic step();
    @(negedge clock);
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    int wait_cnt;
    logic any_drive;
    logic [2:0] e3;
    logic [1:0] e2;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 8'd0; q_fb = 1'b0;
    step(); step();

    // Reset values
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q_exp", q_exp, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    step();

    // SET len=2: three drive cycles, one cycle after accept
    push(OP_SET, 8'd2);
    cmd_valid = 1'b0;
    chk("set_latency_j", j, 0);
    chk("set_latency_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("set_j", j, 1);
      chk("set_k", k, 0);
      chk("set_busy", busy, 1);
      chk("set_state", dbg_state, ST_RUN);
      chk("set_done", done, (i == 2) ? 1 : 0);
      chk("set_q_exp", q_exp, (i > 0) ? 1 : 0);
    end
    step();
    chk("set_after_j", j, 0);
    chk("set_after_k", k, 0);
    chk("set_after_busy", busy, 0);
    chk("set_after_done", done, 0);
    chk("set_after_q_exp", q_exp, 1);

    // RESET len=0 then TOGGLE len=3 back-to-back: {j,k,q_exp} per cycle
    exp_q = {3'b011, 3'b110, 3'b111, 3'b110, 3'b111};
    push(OP_RESET, 8'd0);
    push(OP_TOGGLE, 8'd3);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e3 = exp_q.pop_front();
      chk("b2b_jkq", {j, k, q_exp}, e3);
      chk("b2b_busy", busy, 1);
      chk("b2b_done", done, (i == 0 || i == 4) ? 1 : 0);
      step();
    end
    chk("b2b_after_busy", busy, 0);
    chk("b2b_after_jk", {j, k}, 2'b00);
    chk("b2b_after_q_exp", q_exp, 0);

    // HOLD len=255 then fill the FIFO; fifth push waits for a slot
    push(OP_HOLD, 8'd255);
    push(OP_SET, 8'd0);
    push(OP_RESET, 8'd1);
    push(OP_TOGGLE, 8'd0);
    push(OP_SET, 8'd2);
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_hold_jk", {j, k}, 2'b00);
    cmd_op  = OP_RESET;
    cmd_len = 8'd0;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 400) begin
      step();
      wait_cnt++;
    end
    chk("full_wait_cycles", wait_cnt, 253);
    jk_q = {2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 8; i++) begin
      e2 = jk_q.pop_front();
      chk("drain_jk", {j, k}, e2);
      chk("drain_busy", busy, 1);
      step();
      if (i == 0) cmd_valid = 1'b0;
    end
    chk("drain_after_busy", busy, 0);
    chk("drain_after_jk", {j, k}, 2'b00);
    chk("drain_after_ready", cmd_ready, 1);

    // Reset mid-RUN with a queued command behind it
    push(OP_TOGGLE, 8'd10);
    push(OP_SET, 8'd5);
    cmd_valid = 1'b0;
    step(); step();
    chk("midrun_jk", {j, k}, 2'b11);
    chk("midrun_busy", busy, 1);
    reset = 1'b1;
    step();
    chk("midrst_jk", {j, k}, 2'b00);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q_exp", q_exp, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    any_drive = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      any_drive = any_drive | j | k | busy;
    end
    chk("midrst_no_stale", any_drive, 0);

    // Checker: SET len=0 with q_fb held low
    q_fb = 1'b0;
    push(OP_SET, 8'd0);
    cmd_valid = 1'b0;
    step();
    chk("chk_set_j", j, 1);
    step();
    chk("chk_q_exp", q_exp, 1);
    chk("chk_pre_mismatch", mismatch, 0);
    chk("chk_pre_err_cnt", err_cnt, 0);
    step();
`ifdef JK_SEQ_CHECK_EN
    chk("chk_first_mismatch", mismatch, 1);
    chk("chk_first_err_cnt", err_cnt, 1);
`else
    chk("chk_off_mismatch", mismatch, 0);
    chk("chk_off_err_cnt", err_cnt, 0);
`endif
    repeat (300) step();
`ifdef JK_SEQ_CHECK_EN
    chk("chk_sat_err_cnt", err_cnt, 255);
    chk("chk_sticky_mismatch", mismatch, 1);
`else
    chk("chk_off_sat_err_cnt", err_cnt, 0);
    chk("chk_off_sticky_mismatch", mismatch, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
